// File: rtl/shared_bus_pkg.sv
// Shared-bus arbiter package: bus widths, arbiter state encoding and grant-index sizing.
package shared_bus_pkg;

  localparam int SHARED_ADDR_WIDTH = 16;
  localparam int SHARED_DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit index so grant/rr_ptr never collapse to zero width.
  function automatic int grant_width(input int num_cores);
    return (num_cores <= 1) ? 1 : $clog2(num_cores);
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_picker.sv
// Combinational winner picker for the shared-bus arbiter.
// SHARED_ARB_FIXED_PRIORITY_EN selects lowest-index-wins; otherwise round-robin from i_start.
module rr_picker
  import shared_bus_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = grant_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_start,
  output logic [GW-1:0] o_winner,
  output logic          o_any_req
);

  assign o_any_req = |i_req;

`ifdef SHARED_ARB_FIXED_PRIORITY_EN
  logic w_unused_start;
  assign w_unused_start = ^i_start;

  always_comb begin
    o_winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_winner = GW'(i);
      end
    end
  end
`else
  int w_best;
  int w_dist;

  // Winner is the requester with the smallest upward (wrapping) distance from i_start.
  always_comb begin
    o_winner = '0;
    w_best   = N;
    w_dist   = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= int'(i_start)) ? (i - int'(i_start)) : (i + N - int'(i_start));
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = GW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/shared_bus_arbiter.sv
// Serialises NUM_CORES core requests onto one downstream memory port, one access per grant.
// Build option: define SHARED_ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module shared_bus_arbiter
  import shared_bus_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [SHARED_ADDR_WIDTH*NUM_CORES-1:0] i_core_addr,
  input  logic [NUM_CORES-1:0]                   i_core_wren,
  input  logic [NUM_CORES-1:0]                   i_core_rden,
  input  logic [SHARED_DATA_WIDTH*NUM_CORES-1:0] i_core_write_val,
  output logic [NUM_CORES-1:0]                   o_core_ready,
  output logic [SHARED_DATA_WIDTH-1:0]           o_core_read_val,
  output logic [SHARED_ADDR_WIDTH-1:0]           o_mem_addr,
  output logic                                   o_mem_wren,
  output logic                                   o_mem_rden,
  output logic [SHARED_DATA_WIDTH-1:0]           o_mem_write_val,
  input  logic                                   i_mem_ready,
  input  logic [SHARED_DATA_WIDTH-1:0]           i_mem_read_val
);

  localparam int GW = grant_width(NUM_CORES);

  arb_state_e                   r_state;
  logic [GW-1:0]                r_grant;
  logic [GW-1:0]                w_rr_start;
  logic [GW-1:0]                w_winner;
  logic                         w_any_req;
  logic [NUM_CORES-1:0]         w_req;
  logic [SHARED_ADDR_WIDTH-1:0] w_sel_addr;
  logic [SHARED_DATA_WIDTH-1:0] w_sel_data;
  logic                         w_sel_wren;
  logic                         w_sel_rden;
  logic                         w_sel_req;
  logic                         w_access;
  logic                         w_complete;

  assign w_req = i_core_wren | i_core_rden;

  rr_picker #(
    .N  (NUM_CORES),
    .GW (GW)
  ) u_picker (
    .i_req     (w_req),
    .i_start   (w_rr_start),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_wren = 1'b0;
    w_sel_rden = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (int'(r_grant) == i) begin
        w_sel_addr = i_core_addr[SHARED_ADDR_WIDTH*i +: SHARED_ADDR_WIDTH];
        w_sel_data = i_core_write_val[SHARED_DATA_WIDTH*i +: SHARED_DATA_WIDTH];
        w_sel_wren = i_core_wren[i];
        w_sel_rden = i_core_rden[i];
      end
    end
  end

  assign w_access   = (r_state == ARB_ACCESS);
  assign w_sel_req  = w_sel_wren | w_sel_rden;
  assign w_complete = w_access & w_sel_req & i_mem_ready;

  // Write beats read when a core raises both; a dropped request kills the strobes immediately.
  assign o_mem_addr      = w_access ? w_sel_addr : '0;
  assign o_mem_write_val = w_access ? w_sel_data : '0;
  assign o_mem_wren      = w_access & w_sel_wren;
  assign o_mem_rden      = w_access & w_sel_rden & ~w_sel_wren;
  assign o_core_read_val = i_mem_read_val;

  always_comb begin
    o_core_ready = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      o_core_ready[i] = w_complete && (int'(r_grant) == i);
    end
  end

`ifdef SHARED_ARB_FIXED_PRIORITY_EN
  assign w_rr_start = '0;
`else
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] w_next_ptr;

  // Pointer only moves on a completed access, so an abandoned grant keeps its turn order.
  assign w_next_ptr = (int'(r_grant) >= NUM_CORES - 1) ? '0 : (r_grant + GW'(1));
  assign w_rr_start = r_rr_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_complete) begin
      r_rr_ptr <= w_next_ptr;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_winner;
            r_state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (!w_sel_req || i_mem_ready) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-rule reference model.
module tb_shared_bus_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rstN;
  logic [16*N-1:0] coreAddr;
  logic [16*N-1:0] coreData;
  logic [N-1:0]    coreWren;
  logic [N-1:0]    coreRden;
  logic [N-1:0]    coreReady;
  logic [15:0]     coreReadVal;
  logic [15:0]     memAddr;
  logic [15:0]     memWriteVal;
  logic [15:0]     memReadVal;
  logic            memWren;
  logic            memRden;
  logic            memReady;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [N-1:0] wr;
    logic [N-1:0] rd;
    logic         expWren;
    logic         expRden;
    logic [15:0]  expAddr;
    logic [N-1:0] expReady;
  } vec_t;

  vec_t vecs[7];

  shared_bus_arbiter #(.NUM_CORES(N)) dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .i_core_addr      (coreAddr),
    .i_core_wren      (coreWren),
    .i_core_rden      (coreRden),
    .i_core_write_val (coreData),
    .o_core_ready     (coreReady),
    .o_core_read_val  (coreReadVal),
    .o_mem_addr       (memAddr),
    .o_mem_wren       (memWren),
    .o_mem_rden       (memRden),
    .o_mem_write_val  (memWriteVal),
    .i_mem_ready      (memReady),
    .i_mem_read_val   (memReadVal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    coreAddr   = '0;
    coreData   = '0;
    coreWren   = '0;
    coreRden   = '0;
    memReady   = 1'b0;
    memReadVal = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rstN = 1'b0;
    tick(2);
    rstN = 1'b1;
    tick(1);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < N; i++) begin
      coreAddr[16*i +: 16] = 16'h1000 + 16'(i) * 16'h0111;
      coreData[16*i +: 16] = 16'hA000 + 16'(i);
    end
    coreWren = v.wr;
    coreRden = v.rd;
    memReady = 1'b1;
  endtask

  // Reference model: one access per grant, winner is the first requester at/after the pointer.
  int mOwner = 0;
  int mPtr   = 0;
  bit mBusy  = 1'b0;

  always @(negedge clk) begin : model
    logic [N-1:0] req;
    logic [N-1:0] expReady;
    logic         eW;
    logic         eR;
    if (!rstN) begin
      mBusy = 1'b0;
      mOwner = 0;
      mPtr = 0;
      checkOutput("model_rst_wren", 32'(memWren), 32'd0);
      checkOutput("model_rst_rden", 32'(memRden), 32'd0);
      checkOutput("model_rst_ready", 32'(coreReady), 32'd0);
    end else begin
      req = coreWren | coreRden;
      expReady = '0;
      eW = 1'b0;
      eR = 1'b0;
      if (mBusy && req[mOwner]) begin
        eW = coreWren[mOwner];
        eR = coreRden[mOwner] && !coreWren[mOwner];
        checkOutput("model_addr", 32'(memAddr), 32'(coreAddr[16*mOwner +: 16]));
        if (eW) checkOutput("model_wdata", 32'(memWriteVal), 32'(coreData[16*mOwner +: 16]));
        if (memReady) expReady[mOwner] = 1'b1;
      end
      checkOutput("model_wren", 32'(memWren), 32'(eW));
      checkOutput("model_rden", 32'(memRden), 32'(eR));
      checkOutput("model_ready", 32'(coreReady), 32'(expReady));
      checkOutput("model_rdata", 32'(coreReadVal), 32'(memReadVal));
      if (mBusy) begin
        if (!req[mOwner]) begin
          mBusy = 1'b0;
        end else if (memReady) begin
          mBusy = 1'b0;
`ifndef SHARED_ARB_FIXED_PRIORITY_EN
          mPtr = (mOwner + 1) % N;
`endif
        end
      end else if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(mPtr + k) % N]) begin
            mOwner = (mPtr + k) % N;
            break;
          end
        end
        mBusy = 1'b1;
      end
    end
  end

  initial begin
    logic [N-1:0] rdy;
    int           r;
    logic [N-1:0] expFair;

    rstN = 1'b0;
    clearInputs();
    vecs[0] = '{wr: 4'b0000, rd: 4'b0100, expWren: 1'b0, expRden: 1'b1, expAddr: 16'h1222, expReady: 4'b0100};
    vecs[1] = '{wr: 4'b1111, rd: 4'b0000, expWren: 1'b1, expRden: 1'b0, expAddr: 16'h1000, expReady: 4'b0001};
    vecs[2] = '{wr: 4'b0010, rd: 4'b1000, expWren: 1'b1, expRden: 1'b0, expAddr: 16'h1111, expReady: 4'b0010};
    vecs[3] = '{wr: 4'b0000, rd: 4'b1000, expWren: 1'b0, expRden: 1'b1, expAddr: 16'h1333, expReady: 4'b1000};
    vecs[4] = '{wr: 4'b0001, rd: 4'b0001, expWren: 1'b1, expRden: 1'b0, expAddr: 16'h1000, expReady: 4'b0001};
    vecs[5] = '{wr: 4'b0000, rd: 4'b0000, expWren: 1'b0, expRden: 1'b0, expAddr: 16'h0000, expReady: 4'b0000};
    vecs[6] = '{wr: 4'b1000, rd: 4'b0100, expWren: 1'b0, expRden: 1'b1, expAddr: 16'h1222, expReady: 4'b0100};

    tick(2);
    @(negedge clk);
    checkOutput("reset_wren", 32'(memWren), 32'd0);
    checkOutput("reset_rden", 32'(memRden), 32'd0);
    checkOutput("reset_ready", 32'(coreReady), 32'd0);
    checkOutput("reset_addr", 32'(memAddr), 32'd0);

    // First grant after reset for each vector: lowest requester, write beats read.
    for (int v = 0; v < 7; v++) begin
      doReset();
      applyStimulus(vecs[v]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_idle_wren", v), 32'(memWren), 32'd0);
      tick(1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_wren", v), 32'(memWren), 32'(vecs[v].expWren));
      checkOutput($sformatf("vec%0d_rden", v), 32'(memRden), 32'(vecs[v].expRden));
      checkOutput($sformatf("vec%0d_ready", v), 32'(coreReady), 32'(vecs[v].expReady));
      if (vecs[v].expWren || vecs[v].expRden)
        checkOutput($sformatf("vec%0d_addr", v), 32'(memAddr), 32'(vecs[v].expAddr));
    end

    // Single read from slot 2 with data one cycle after completion.
    doReset();
    coreAddr[16*2 +: 16] = 16'h4010;
    coreRden[2] = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    tick(1);
    @(negedge clk);
    checkOutput("rd_rden", 32'(memRden), 32'd1);
    checkOutput("rd_addr", 32'(memAddr), 32'h4010);
    checkOutput("rd_ready", 32'(coreReady), 32'b0100);
    tick(1);
    coreRden[2] = 1'b0;
    memReadVal = 16'hBEEF;
    @(negedge clk);
    checkOutput("rd_rden_once", 32'(memRden), 32'd0);
    checkOutput("rd_data", 32'(coreReadVal), 32'hBEEF);

    // All four slots write at once; each drops after its ready.
    doReset();
    for (int i = 0; i < N; i++) begin
      coreAddr[16*i +: 16] = 16'h2000 + 16'(i);
      coreData[16*i +: 16] = 16'h5A00 + 16'(i);
    end
    coreWren = 4'b1111;
    memReady = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      tick(1);
      @(negedge clk);
      checkOutput($sformatf("all4_ready%0d", k), 32'(coreReady), 32'(4'b0001 << k));
      checkOutput($sformatf("all4_wdata%0d", k), 32'(memWriteVal), 32'(16'h5A00 + 16'(k)));
      tick(1);
      coreWren[k] = 1'b0;
    end

    // Slots 0 and 3 request continuously.
    doReset();
    coreWren = 4'b1001;
    memReady = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      @(negedge clk);
`ifdef SHARED_ARB_FIXED_PRIORITY_EN
      expFair = 4'b0001;
`else
      expFair = (k % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
      checkOutput($sformatf("fair_grant%0d", k), 32'(coreReady), 32'(expFair));
      tick(1);
      @(negedge clk);
    end

    // Stall: mem_ready low for five ACCESS cycles.
    doReset();
    coreAddr[16*1 +: 16] = 16'h8000;
    coreData[16*1 +: 16] = 16'h1234;
    coreWren[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      @(negedge clk);
      checkOutput($sformatf("stall_wren%0d", k), 32'(memWren), 32'd1);
      checkOutput($sformatf("stall_addr%0d", k), 32'(memAddr), 32'h8000);
      checkOutput($sformatf("stall_data%0d", k), 32'(memWriteVal), 32'h1234);
      checkOutput($sformatf("stall_ready%0d", k), 32'(coreReady), 32'd0);
    end
    tick(1);
    memReady = 1'b1;
    @(negedge clk);
    checkOutput("stall_done_ready", 32'(coreReady), 32'b0010);
    tick(1);
    coreWren[1] = 1'b0;

    // Reset during ACCESS after the pointer has moved past slot 1.
    doReset();
    coreWren[1] = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    tick(1);
    @(negedge clk);
    checkOutput("rstmid_pre_ready", 32'(coreReady), 32'b0010);
    tick(1);
    coreWren[1] = 1'b0;
    coreWren[3] = 1'b1;
    memReady = 1'b0;
    @(negedge clk);
    tick(1);
    @(negedge clk);
    checkOutput("rstmid_access_wren", 32'(memWren), 32'd1);
    tick(1);
    rstN = 1'b0;
    coreWren[1] = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_wren", 32'(memWren), 32'd0);
    checkOutput("rstmid_rden", 32'(memRden), 32'd0);
    checkOutput("rstmid_ready", 32'(coreReady), 32'd0);
    tick(1);
    rstN = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    tick(1);
    @(negedge clk);
    checkOutput("rstmid_after_grant", 32'(coreReady), 32'b0010);

    // Randomized traffic, checked by the reference model every cycle.
    doReset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rdy = coreReady;
      tick(1);
      for (int i = 0; i < N; i++) begin
        if (coreWren[i] || coreRden[i]) begin
          if (rdy[i] || ($urandom_range(0, 40) == 0)) begin
            coreWren[i] = 1'b0;
            coreRden[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          r = int'($urandom_range(0, 3));
          coreWren[i] = (r != 2);
          coreRden[i] = (r >= 2);
          coreAddr[16*i +: 16] = 16'($urandom);
          coreData[16*i +: 16] = 16'($urandom);
        end
      end
      memReady = ($urandom_range(0, 2) != 0);
      memReadVal = 16'($urandom);
    end
    tick(1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Arbitrates the 16-bit shared bus (global memory and device registers) between NUM_CORES cores. Each core's shared_* port connects to one requester slot. The arbiter serialises accesses to a single downstream memory port and returns a per-core ready that stalls every loser. Read data is broadcast on one bus, keeping each core's one-cycle-delayed read capture unchanged.

## Interface
- NUM_CORES, 4, number of requester slots (1..16)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; state cleared while 0
- core_addr  input  16*NUM_CORES  packed per-core address, slot i at [16*i+15:16*i]
- core_wren  input  NUM_CORES  per-core write request
- core_rden  input  NUM_CORES  per-core read request
- core_write_val  input  16*NUM_CORES  packed per-core write data
- core_ready  output  NUM_CORES  per-core access-complete strobe
- core_read_val  output  16  broadcast read data
- mem_addr  output  16  downstream address
- mem_wren  output  1  downstream write strobe
- mem_rden  output  1  downstream read strobe
- mem_write_val  output  16  downstream write data
- mem_ready  input  1  downstream completes current access this cycle
- mem_read_val  input  16  downstream read data, valid the cycle after mem_ready

## Operation
- Request from slot i: core_wren[i] | core_rden[i]. A core holds its request stable until it sees core_ready[i]=1.
- States:
  - IDLE: if any request is present, latch the winner into grant and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_* = slot[grant] signals (combinational mux). When mem_ready=1: core_ready[grant]=1, rr_ptr <= grant+1 (NUM_CORES-1 wraps to 0), go to IDLE.
- Round-robin: the winner is the first requesting slot at or after rr_ptr, scanning upward with wrap.
- mem_wren and mem_rden are 0 in IDLE. core_ready is 0 for every non-granted slot and 0 in IDLE.
- If slot[grant] has both wren and rden set, write wins and mem_rden is forced to 0.
- If slot[grant] drops its request in ACCESS before mem_ready: mem strobes go to 0 that cycle, core_ready is not asserted, return to IDLE, rr_ptr unchanged.
- core_read_val = mem_read_val as a pure pass-through. Only the core that just completed a read samples it.

## Timing
- Reset values: state=IDLE, grant=0, rr_ptr=0. All mem_* outputs 0 and core_ready=0, because outputs are decoded from state.
- Latency: request seen in IDLE at cycle N. mem strobes assert in N+1. Earliest core_ready is N+1 (mem_ready same cycle). Read data is valid in N+2.
- Throughput: at most one access per 2 cycles; each completed access passes through one IDLE cycle.
- A new request that arrives during ACCESS waits; it is considered in the next IDLE cycle.
- A request that arrives in the same IDLE cycle as others competes immediately.
- Reset asserted mid-ACCESS drops strobes at once with no core_ready. A downstream access in flight is abandoned.
- NUM_CORES=1: grant and rr_ptr are 1 bit wide, tied to 0.

## Configuration
- SHARED_ARB_FIXED_PRIORITY_EN
  - Defined: the winner is always the lowest-indexed requesting slot. rr_ptr and its update logic are removed.
  - Undefined: round-robin as described above.

## Structure
- shared_bus_pkg holds:
  - SHARED_ADDR_WIDTH=16 and SHARED_DATA_WIDTH=16
  - state encodings ARB_IDLE and ARB_ACCESS
  - the function for grant-index width, max(1, $clog2(NUM_CORES))
- Sub-module rr_picker: takes a request vector and a start pointer, returns the winner index and any_req. It is purely combinational, with the fixed-priority variant under the macro.

## Test plan
- Single read: slot 2 asserts rden with addr 0x4010, and mem_ready=1 on the first ACCESS cycle. mem_rden is 1 for exactly one cycle. core_ready=0b0100. core_read_val shows mem_read_val (0xBEEF) one cycle later.
- All four slots request writes at once and mem_ready is held at 1. Grants go in order 0,1,2,3, each core_ready pulses once, and mem_write_val matches each slot's data.
- Round-robin fairness: slots 0 and 3 request continuously. Grants alternate 0,3,0,3 (the macro-defined build gives only 0 until slot 0 drops).
- Stall: slot 1 writes 0x1234 to 0x8000 while mem_ready is held low for 5 cycles. Strobes and addr stay stable, and core_ready stays 0 until the 6th ACCESS cycle.
- Reset driven to 0 during ACCESS: next cycle mem_wren=mem_rden=0 and core_ready=0. After release, the first grant goes to the lowest requester.
- Slot 0 sets both wren and rden. mem_wren=1 and mem_rden=0.
